uart_transmit: RTL and testbench
================================

Name: uart_transmit

Overview:
- Serial UART transmitter: accepts one byte per valid/ready handshake from the parallel side and drives it onto tx_o as a framed asynchronous word.
- Frame: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
- Counterpart of the UART receiver; both sit between board logic and the FPGA UART pins.
- A one-entry holding register allows back-to-back frames with no idle gap.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- data_i  in  8  byte to send; only bits [DATA_BITS-1:0] are transmitted
- data_valid_i  in  1  data_i is valid this cycle
- data_ready_o  out  1  holding register empty; a byte is accepted when valid and ready are both high at a rising clk
- tx_o  out  1  serial line, idle high; registered output
- busy_o  out  1  a frame is in progress (state != IDLE) or the holding register is full

Behaviour:
- Reset, synchronous and active-high on clk:
  - tx_o = 1, data_ready_o = 1, busy_o = 0.
  - State = IDLE; bit counter, baud counter and holding register cleared.
  - A reset asserted mid-frame aborts the frame. tx_o is 1 on the cycle after the reset edge; no partial stop bit is emitted.
- Handshake:
  - Accept at edge N when data_valid_i && data_ready_o.
  - data_ready_o is the registered inverse of the holding-register full flag, so it drops from cycle N+1.
  - Data presented while data_ready_o = 0 is ignored; no stall on the data path.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START at the first edge where the holding register is full. At that edge the shift register loads, the holding register empties, and tx_o becomes 0.
  - Accept-to-start latency: byte accepted at edge N gives tx_o low from edge N+1 when starting from IDLE.
  - START: tx_o = 0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA: DATA_BITS bits, LSB first, each held exactly CLKS_PER_BIT cycles. Then -> PARITY if PARITY != 0, else -> STOP.
  - PARITY: transmits the XOR of the data bits (even mode) or its inverse (odd mode) for one bit time.
  - STOP: tx_o = 1 for STOP_BITS*CLKS_PER_BIT cycles. At the last cycle: -> START if the holding register is full (no idle gap, the holding register loads), else -> IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; width is clog2(CLKS_PER_BIT).
  - Reset to 0 on every state entry, so the wrap is the bit boundary.
  - Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles exactly.
- Simultaneous events:
  - The FSM may drain the holding register in the same cycle that a new accept would occur. Because data_ready_o is registered, the new accept happens at the earliest one cycle later.
  - With back-to-back traffic, the second byte is therefore accepted during the first frame, well before the STOP state ends.
- Glitch-free line: tx_o changes only on bit boundaries and is driven from a flop.

Decomposition:
- Package uart_pkg holds definitions shared with the receiver:
  - state encoding localparams
  - UART_START_BIT = 1'b0, UART_STOP_BIT = 1'b1, UART_IDLE_LEVEL = 1'b1
  - parity mode constants
  - a clog2-based counter width function
- One natural sub-module: uart_baud_counter.
  - Parameter CLKS_PER_BIT; inputs clk, reset, restart_i; output bit_done_o, a one-cycle pulse when the count wraps.
  - The receiver reuses it with a half-bit restart for mid-bit sampling.

Test Plan (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless noted):
- Reset check: assert reset for 3 cycles -> tx_o = 1, data_ready_o = 1, busy_o = 0. No transitions for 20 cycles with data_valid_i = 0.
- Single byte: send 0xA5 at edge N -> tx_o low at N+1 for 4 cycles. Data sequence 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles; frame = 40 cycles. busy_o falls at N+41 and data_ready_o is 1 from N+2.
- Back-to-back: send 0x00 and hold data_valid_i with 0xFF -> 0xFF accepted during frame 1. Start bit of frame 2 begins on the cycle right after frame 1's stop bit; total 80 cycles, no idle gap.
- Parity and stop variants: PARITY=1 with 0x07 -> parity bit 1. PARITY=2 with 0x07 -> 0. PARITY=1, STOP_BITS=2 -> 48-cycle frame with an 8-cycle high stop.
- Reset mid-frame: reset in DATA bit 3 of 0x3C -> tx_o = 1 the next cycle and stays idle. A new byte 0x81 afterwards produces a clean 40-cycle frame.
- Ignored write: pulse data_valid_i with 0x55 while data_ready_o = 0 -> no extra frame on tx_o; only the two accepted bytes appear.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: FSM encoding,
// line levels, parity modes and small helper functions.
package uart_pkg;

  // State encoding shared with the receiver
  localparam logic [2:0] UART_ST_IDLE   = 3'd0;
  localparam logic [2:0] UART_ST_START  = 3'd1;
  localparam logic [2:0] UART_ST_DATA   = 3'd2;
  localparam logic [2:0] UART_ST_PARITY = 3'd3;
  localparam logic [2:0] UART_ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = UART_ST_IDLE,
    ST_START  = UART_ST_START,
    ST_DATA   = UART_ST_DATA,
    ST_PARITY = UART_ST_PARITY,
    ST_STOP   = UART_ST_STOP
  } uart_state_e;

  // Line levels
  localparam logic UART_START_BIT  = 1'b0;
  localparam logic UART_STOP_BIT   = 1'b1;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Parity modes
  localparam int UART_PARITY_NONE = 0;
  localparam int UART_PARITY_EVEN = 1;
  localparam int UART_PARITY_ODD  = 2;

  // Width of a counter that has to hold 0..n-1 (never narrower than one bit)
  function automatic int uart_cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Parity over the low data_bits bits; odd mode inverts the even result
  function automatic logic uart_parity(input logic [7:0] data, input int data_bits,
                                       input int mode);
    logic p;
    p = (mode == UART_PARITY_ODD);
    for (int i = 0; i < 8; i++) begin
      p = p ^ (data[i] & (i < data_bits));
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. restart_i forces the count back to zero (the receiver restarts
// it at a half-bit offset for mid-bit sampling).
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic restart_i,
  output logic bit_done_o
);

  localparam int CW = uart_cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Next count: restart or wrap to zero, otherwise increment
  always_comb begin
    count_next = count;
    if (restart_i) begin
      count_next = '0;
    end else if (count == LAST) begin
      count_next = '0;
    end else begin
      count_next = count + CW'(1);
    end
  end

  // Count register; bit_done_o is registered and high while count == LAST
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      bit_done_o <= 1'b0;
    end else begin
      count      <= count_next;
      bit_done_o <= (count_next == LAST);
    end
  end

endmodule

// File: rtl/uart_transmit.sv
// UART transmitter: one-entry holding register behind a valid/ready
// handshake, feeding a frame FSM (start, data LSB first, optional parity,
// stop bits). All outputs come straight from flops.
module uart_transmit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_i,
  input  logic       data_valid_i,
  output logic       data_ready_o,
  output logic       tx_o,
  output logic       busy_o
);

  uart_state_e state;
  logic [7:0]  hold_data;
  logic        hold_full;
  logic [7:0]  shift;
  logic        parity_bit;
  logic [2:0]  bit_cnt;
  logic        bit_done;

  logic accept;
  logic last_data;
  logic last_stop;
  logic frame_end;
  logic start_frame;
  logic go_idle;
  logic hold_full_next;

  // The counter is held at zero while idle. Every other state change happens
  // on a wrap, so the count is already zero on entry to the new state.
  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .reset     (reset),
    .restart_i (state == ST_IDLE),
    .bit_done_o(bit_done)
  );

  // Handshake and frame-sequencing decisions for this cycle
  always_comb begin
    accept      = data_valid_i && data_ready_o;
    last_data   = (bit_cnt == 3'(DATA_BITS - 1));
    last_stop   = (bit_cnt == 3'(STOP_BITS - 1));
    frame_end   = (state == ST_STOP) && bit_done && last_stop;
    start_frame = hold_full && ((state == ST_IDLE) || frame_end);
    go_idle     = frame_end && !hold_full;
    if (accept) begin
      hold_full_next = 1'b1;
    end else if (start_frame) begin
      hold_full_next = 1'b0;
    end else begin
      hold_full_next = hold_full;
    end
  end

  // Holding register, status flags and the frame FSM driving tx_o
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      hold_data    <= 8'h00;
      hold_full    <= 1'b0;
      shift        <= 8'h00;
      parity_bit   <= 1'b0;
      bit_cnt      <= 3'd0;
      tx_o         <= UART_IDLE_LEVEL;
      data_ready_o <= 1'b1;
      busy_o       <= 1'b0;
    end else begin
      hold_full    <= hold_full_next;
      data_ready_o <= !hold_full_next;
      busy_o       <= hold_full_next || start_frame || ((state != ST_IDLE) && !go_idle);
      if (accept) begin
        hold_data <= data_i;
      end
      if (start_frame) begin
        // From IDLE or the last stop cycle: load the next byte, no gap
        state      <= ST_START;
        tx_o       <= UART_START_BIT;
        shift      <= hold_data;
        parity_bit <= uart_parity(hold_data, DATA_BITS, PARITY);
        bit_cnt    <= 3'd0;
      end else begin
        case (state)
          ST_IDLE: begin
            tx_o <= UART_IDLE_LEVEL;
          end
          ST_START: begin
            if (bit_done) begin
              state   <= ST_DATA;
              tx_o    <= shift[0];
              shift   <= {1'b0, shift[7:1]};
              bit_cnt <= 3'd0;
            end
          end
          ST_DATA: begin
            if (bit_done) begin
              if (last_data) begin
                bit_cnt <= 3'd0;
                if (PARITY != UART_PARITY_NONE) begin
                  state <= ST_PARITY;
                  tx_o  <= parity_bit;
                end else begin
                  state <= ST_STOP;
                  tx_o  <= UART_STOP_BIT;
                end
              end else begin
                tx_o    <= shift[0];
                shift   <= {1'b0, shift[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          ST_PARITY: begin
            if (bit_done) begin
              state   <= ST_STOP;
              tx_o    <= UART_STOP_BIT;
              bit_cnt <= 3'd0;
            end
          end
          ST_STOP: begin
            if (bit_done) begin
              if (last_stop) begin
                state   <= ST_IDLE;
                tx_o    <= UART_IDLE_LEVEL;
                bit_cnt <= 3'd0;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            tx_o  <= UART_IDLE_LEVEL;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_transmit.sv
// Self-checking bench for uart_transmit with CLKS_PER_BIT=4. dut0 (no parity,
// one stop bit) is checked by a scoreboard monitor; dut1..dut3 cover the
// parity and two-stop-bit variants.
module tb_uart_transmit;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data0;
  logic       valid0;
  logic [7:0] data_p;
  logic       valid_p;
  logic [3:0] tx_v;
  logic [3:0] busy_v;
  logic [3:0] ready_v;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  int start_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_transmit #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .data_i(data0), .data_valid_i(valid0),
    .data_ready_o(ready_v[0]), .tx_o(tx_v[0]), .busy_o(busy_v[0]));

  uart_transmit #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .data_i(data_p), .data_valid_i(valid_p),
    .data_ready_o(ready_v[1]), .tx_o(tx_v[1]), .busy_o(busy_v[1]));

  uart_transmit #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(reset), .data_i(data_p), .data_valid_i(valid_p),
    .data_ready_o(ready_v[2]), .tx_o(tx_v[2]), .busy_o(busy_v[2]));

  uart_transmit #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut3 (
    .clk(clk), .reset(reset), .data_i(data_p), .data_valid_i(valid_p),
    .data_ready_o(ready_v[3]), .tx_o(tx_v[3]), .busy_o(busy_v[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Expected line bits, index 0 = start bit, in transmission order
  function automatic logic [11:0] frame_word(input logic [7:0] d, input int has_par,
                                             input logic par, input int stops);
    logic [11:0] w;
    int pos;
    w = 12'd0;
    w[8:1] = d;
    pos = 9;
    if (has_par != 0) begin
      w[pos] = par;
      pos++;
    end
    for (int i = 0; i < stops; i++) begin
      w[pos] = 1'b1;
      pos++;
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic at_cycle(input int t);
    do @(negedge clk); while (cyc < t);
  endtask

  // Called on the negedge of the first start-bit cycle; samples every cycle
  task automatic capture(input int idx, input int nbits, output logic [11:0] bits,
                         output logic glitch, output logic aborted);
    logic s;
    bits = 12'd0;
    glitch = 1'b0;
    aborted = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (reset) begin
          aborted = 1'b1;
          return;
        end
        s = tx_v[idx];
        if (c == 0) bits[b] = s;
        else if (s !== bits[b]) glitch = 1'b1;
      end
    end
  endtask

  task automatic send0(input logic [7:0] d, output int acc);
    data0 = d;
    valid0 = 1'b1;
    acc = cyc + 1;
    tick();
    valid0 = 1'b0;
  endtask

  task automatic watch(input int idx, input int nbits, input logic [11:0] want,
                       input int acc, input string name);
    logic [11:0] bits;
    logic glitch;
    logic aborted;
    int waited;
    waited = 0;
    @(negedge clk);
    while (tx_v[idx] !== 1'b0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_start_seen"}, 32'(tx_v[idx] === 1'b0), 32'd1);
    if (tx_v[idx] === 1'b0) begin
      check({name, "_start_cycle"}, 32'(cyc), 32'(acc + 1));
      capture(idx, nbits, bits, glitch, aborted);
      check({name, "_bits"}, 32'(bits), 32'(want));
      check({name, "_glitch"}, 32'(glitch), 32'd0);
      check({name, "_busy_last"}, 32'(busy_v[idx]), 32'd1);
      @(negedge clk);
      check({name, "_busy_end"}, 32'(busy_v[idx]), 32'd0);
      check({name, "_tx_end"}, 32'(tx_v[idx]), 32'd1);
    end
  endtask

  // Scoreboard monitor for dut0: every frame on the line pops one byte
  initial begin : monitor0
    logic [11:0] bits;
    logic glitch;
    logic aborted;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (!reset && tx_v[0] === 1'b0) begin
        start_q.push_back(cyc);
        capture(0, 10, bits, glitch, aborted);
        check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          want = exp_q.pop_front();
          if (!aborted) begin
            check("frame_bits", 32'(bits), 32'(frame_word(want, 0, 1'b0, 1)));
            check("frame_glitch", 32'(glitch), 32'd0);
          end
        end
      end
    end
  end

  initial begin : main
    int acc;
    int s;
    int bad;
    reset = 1'b1;
    data0 = 8'h00;
    valid0 = 1'b0;
    data_p = 8'h00;
    valid_p = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_tx", 32'(tx_v), 32'hF);
    check("reset_ready", 32'(ready_v), 32'hF);
    check("reset_busy", 32'(busy_v), 32'h0);
    reset = 1'b0;

    // Quiet line with no traffic
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_v !== 4'hF || busy_v !== 4'h0 || ready_v !== 4'hF) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);

    // Single byte 0xA5
    tick();
    exp_q.push_back(8'hA5);
    send0(8'hA5, acc);
    at_cycle(acc);
    check("single_ready_drop", 32'(ready_v[0]), 32'd0);
    check("single_busy_rise", 32'(busy_v[0]), 32'd1);
    at_cycle(acc + 1);
    check("single_ready_back", 32'(ready_v[0]), 32'd1);
    check("single_tx_start", 32'(tx_v[0]), 32'd0);
    at_cycle(acc + 40);
    check("single_busy_last", 32'(busy_v[0]), 32'd1);
    at_cycle(acc + 41);
    check("single_busy_fall", 32'(busy_v[0]), 32'd0);
    check("single_tx_idle", 32'(tx_v[0]), 32'd1);
    check("single_frames", 32'(start_q.size()), 32'd1);
    if (start_q.size() > 0) check("single_start", 32'(start_q.pop_front()), 32'(acc + 1));

    // Back-to-back 0x00 then 0xFF, plus a write while not ready
    tick();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    data0 = 8'h00;
    valid0 = 1'b1;
    acc = cyc + 1;
    tick();
    data0 = 8'hFF;
    tick();
    tick();
    valid0 = 1'b0;
    at_cycle(acc + 2);
    check("b2b_second_taken", 32'(ready_v[0]), 32'd0);
    tick_to(acc + 10);
    data0 = 8'h55;
    valid0 = 1'b1;
    tick();
    valid0 = 1'b0;
    at_cycle(acc + 80);
    check("b2b_busy_last", 32'(busy_v[0]), 32'd1);
    at_cycle(acc + 81);
    check("b2b_busy_fall", 32'(busy_v[0]), 32'd0);
    check("b2b_frames", 32'(start_q.size()), 32'd2);
    if (start_q.size() > 1) begin
      check("b2b_start1", 32'(start_q.pop_front()), 32'(acc + 1));
      check("b2b_start2_no_gap", 32'(start_q.pop_front()), 32'(acc + 41));
    end
    at_cycle(acc + 121);
    check("ignored_write_no_frame", 32'(start_q.size()), 32'd0);
    check("ignored_write_sb", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 3 of 0x3C
    tick();
    exp_q.push_back(8'h3C);
    send0(8'h3C, acc);
    s = acc + 1;
    tick_to(s + 17);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    at_cycle(s + 18);
    check("abort_tx", 32'(tx_v[0]), 32'd1);
    check("abort_busy", 32'(busy_v[0]), 32'd0);
    check("abort_ready", 32'(ready_v[0]), 32'd1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
    end
    check("abort_stays_idle", 32'(bad), 32'd0);
    check("abort_frames", 32'(start_q.size()), 32'd1);
    if (start_q.size() > 0) check("abort_start", 32'(start_q.pop_front()), 32'(s));

    // Clean frame after the abort
    tick();
    exp_q.push_back(8'h81);
    send0(8'h81, acc);
    at_cycle(acc + 40);
    check("after_abort_busy_last", 32'(busy_v[0]), 32'd1);
    at_cycle(acc + 41);
    check("after_abort_busy_fall", 32'(busy_v[0]), 32'd0);
    check("after_abort_frames", 32'(start_q.size()), 32'd1);
    if (start_q.size() > 0) check("after_abort_start", 32'(start_q.pop_front()), 32'(acc + 1));

    // Parity and stop-bit variants with 0x07 (three ones: even parity bit 1)
    tick();
    data_p = 8'h07;
    valid_p = 1'b1;
    acc = cyc + 1;
    tick();
    valid_p = 1'b0;
    fork
      watch(1, 11, frame_word(8'h07, 1, 1'b1, 1), acc, "even");
      watch(2, 11, frame_word(8'h07, 1, 1'b0, 1), acc, "odd");
      watch(3, 12, frame_word(8'h07, 1, 1'b1, 2), acc, "even_2stop");
    join

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("dut0_no_stray_frame", 32'(start_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
